imm_decode_stage: RTL and testbench

- Pipelined decode register between instruction fetch and the immediate extend unit (the 3-bit-select, six-field extender).
- Accepts 32-bit RV32I instruction words with a valid/ready handshake and classifies the opcode into the extender's 3-bit select.
- Slices the raw immediate fields into the six extender inputs and presents them registered, with the PC alongside.
- Includes a 2-entry skid buffer so upstream ready is registered and never combinationally depends on downstream ready.

---
 rtl/imm_decode_stage.sv | 178 +++++++++++++++++
 tb/tb_imm_decode_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// Decode register between fetch and the immediate extender: classifies the RV32I opcode,
// slices the six immediate fields and buffers decoded entries in a two-slot skid buffer.
module imm_decode_stage #(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [2:0]      out_sel,
   output logic [11:0]     out_mux2,
   output logic [4:0]      out_mux3,
   output logic [11:0]     out_mux4,
   output logic [19:0]     out_mux5,
   output logic [19:0]     out_mux6,
   output logic [11:0]     out_mux7,
   output logic            out_illegal
);

   typedef enum logic [6:0] {
      OP_IMM    = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_JALR   = 7'b1100111,
      OP_STORE  = 7'b0100011,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_BRANCH = 7'b1100011,
      OP_REG    = 7'b0110011
   } opcode_e;

   typedef enum logic [2:0] {
      SEL_I     = 3'b000,
      SEL_JALR  = 3'b001,
      SEL_SHAMT = 3'b010,
      SEL_S     = 3'b011,
      SEL_U     = 3'b100,
      SEL_J     = 3'b101,
      SEL_B     = 3'b110,
      SEL_NONE  = 3'b111
   } sel_e;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [2:0]      sel;
      logic [11:0]     mux2;
      logic [4:0]      mux3;
      logic [11:0]     mux4;
      logic [19:0]     mux5;
      logic [19:0]     mux6;
      logic [11:0]     mux7;
      logic            illegal;
   } entry_t;

   entry_t dec;
   entry_t main_q;
   entry_t skid_q;
   occ_e   occ_q;
   occ_e   occ_d;
   logic   acc;
   logic   emit;
   logic   load_main;
   logic   load_skid;
   logic   skid_to_main;

   always_comb begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.mux2    = in_instr[31:20];
      dec.mux3    = in_instr[24:20];
      dec.mux4    = {in_instr[31:25], in_instr[11:7]};
      dec.mux5    = in_instr[31:12];
      dec.mux6    = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};
      dec.mux7    = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
      dec.sel     = SEL_NONE;
      dec.illegal = 1'b0;
      case (in_instr[6:0])
         OP_IMM: begin
            // Only the shift forms use the shamt field
            if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) dec.sel = SEL_SHAMT;
            else                                                         dec.sel = SEL_I;
         end
         OP_LOAD:          dec.sel = SEL_I;
         OP_JALR:          dec.sel = SEL_JALR;
         OP_STORE:         dec.sel = SEL_S;
         OP_LUI, OP_AUIPC: dec.sel = SEL_U;
         OP_JAL:           dec.sel = SEL_J;
         OP_BRANCH:        dec.sel = SEL_B;
         OP_REG:           dec.sel = SEL_NONE;
         default: begin
            dec.sel     = SEL_NONE;
            dec.illegal = 1'b1;
         end
      endcase
   end

   // Handshake flags depend only on the registered occupancy
   assign in_ready  = (occ_q != OCC_TWO);
   assign out_valid = (occ_q != OCC_EMPTY);
   assign acc       = in_valid & in_ready;
   assign emit      = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) occ_q <= OCC_EMPTY;
      else        occ_q <= occ_d;
   end

   always_comb begin
      occ_d        = occ_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      if (flush) begin
         occ_d = OCC_EMPTY;
      end else begin
         case (occ_q)
            OCC_EMPTY: begin
               if (acc) begin
                  load_main = 1'b1;
                  occ_d     = OCC_ONE;
               end
            end
            OCC_ONE: begin
               case ({acc, emit})
                  2'b11: load_main = 1'b1;
                  2'b10: begin
                     load_skid = 1'b1;
                     occ_d     = OCC_TWO;
                  end
                  2'b01: occ_d = OCC_EMPTY;
                  default: occ_d = OCC_ONE;
               endcase
            end
            OCC_TWO: begin
               if (emit) begin
                  skid_to_main = 1'b1;
                  occ_d        = OCC_ONE;
               end
            end
            default: occ_d = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main)         main_q <= dec;
         else if (skid_to_main) main_q <= skid_q;
         if (load_skid)         skid_q <= dec;
      end
   end

   assign out_pc      = main_q.pc;
   assign out_sel     = main_q.sel;
   assign out_mux2    = main_q.mux2;
   assign out_mux3    = main_q.mux3;
   assign out_mux4    = main_q.mux4;
   assign out_mux5    = main_q.mux5;
   assign out_mux6    = main_q.mux6;
   assign out_mux7    = main_q.mux7;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed steps plus random traffic against a
// queue-based reference of the decode stage.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [2:0]  out_sel;
   logic [11:0] out_mux2;
   logic [4:0]  out_mux3;
   logic [11:0] out_mux4;
   logic [19:0] out_mux5;
   logic [19:0] out_mux6;
   logic [11:0] out_mux7;
   logic        out_illegal;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [2:0]  sel;
      logic [11:0] m2;
      logic [4:0]  m3;
      logic [11:0] m4;
      logic [19:0] m5;
      logic [19:0] m6;
      logic [11:0] m7;
      logic        ill;
   } exp_t;

   exp_t q[$];

   imm_decode_stage #(.PC_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_sel(out_sel),
      .out_mux2(out_mux2), .out_mux3(out_mux3), .out_mux4(out_mux4), .out_mux5(out_mux5),
      .out_mux6(out_mux6), .out_mux7(out_mux7), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t r;
      int unsigned w;
      w     = ins;
      r.pc  = pc;
      r.ill = 1'b0;
      case (w % 128)
         'h13:       r.sel = (((w >> 12) % 8) == 1 || ((w >> 12) % 8) == 5) ? 3'd2 : 3'd0;
         'h03:       r.sel = 3'd0;
         'h67:       r.sel = 3'd1;
         'h23:       r.sel = 3'd3;
         'h37, 'h17: r.sel = 3'd4;
         'h6F:       r.sel = 3'd5;
         'h63:       r.sel = 3'd6;
         'h33:       r.sel = 3'd7;
         default: begin
            r.sel = 3'd7;
            r.ill = 1'b1;
         end
      endcase
      r.m2 = 12'(w >> 20);
      r.m3 = 5'((w >> 20) % 32);
      r.m4 = 12'(((w >> 25) * 32) + ((w >> 7) % 32));
      r.m5 = 20'(w >> 12);
      r.m6 = 20'(((w >> 31) << 19) + (((w >> 12) % 256) << 11) + (((w >> 20) % 2) << 10)
                 + ((w >> 21) % 1024));
      r.m7 = 12'(((w >> 31) << 11) + (((w >> 7) % 2) << 10) + (((w >> 25) % 64) << 4)
                 + ((w >> 8) % 16));
      return r;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 10))
         0: w[6:0] = 7'h13;
         1: w[6:0] = 7'h03;
         2: w[6:0] = 7'h67;
         3: w[6:0] = 7'h23;
         4: w[6:0] = 7'h37;
         5: w[6:0] = 7'h17;
         6: w[6:0] = 7'h6F;
         7: w[6:0] = 7'h63;
         8: w[6:0] = 7'h33;
         9: begin
            w[6:0]   = 7'h13;
            w[14:12] = 3'b101;
         end
         default: ;
      endcase
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare the DUT against the model, advance the model, then step one clock
   task automatic cyc();
      exp_t h;
      exp_t n;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
         h = q[0];
         chk("pc", out_pc, h.pc);
         chk("sel", 32'(out_sel), 32'(h.sel));
         chk("mux2", 32'(out_mux2), 32'(h.m2));
         chk("mux3", 32'(out_mux3), 32'(h.m3));
         chk("mux4", 32'(out_mux4), 32'(h.m4));
         chk("mux5", 32'(out_mux5), 32'(h.m5));
         chk("mux6", 32'(out_mux6), 32'(h.m6));
         chk("mux7", 32'(out_mux7), 32'(h.m7));
         chk("illegal", 32'(out_illegal), 32'(h.ill));
      end
      if (flush) begin
         q.delete();
      end else begin
         n = ref_decode(in_instr, in_pc);
         if (in_valid && q.size() < 2) begin
            if (out_ready && q.size() > 0) void'(q.pop_front());
            q.push_back(n);
         end else if (out_ready && q.size() > 0) begin
            void'(q.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic single(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic reset_outputs_chk(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_pc"}, out_pc, 32'd0);
      chk({tag, "_sel"}, 32'(out_sel), 32'd0);
      chk({tag, "_mux5"}, 32'(out_mux5), 32'd0);
      chk({tag, "_ill"}, 32'(out_illegal), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b1;
      #2;
      reset_outputs_chk("reset");
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single entry from empty
      single(32'h00500093, 32'h100);
      chk("addi_valid", 32'(out_valid), 32'd1);
      chk("addi_sel", 32'(out_sel), 32'd0);
      chk("addi_mux2", 32'(out_mux2), 32'h005);
      chk("addi_pc", out_pc, 32'h100);
      chk("addi_ill", 32'(out_illegal), 32'd0);
      cyc();

      // Opcode sweep
      single(32'h00209093, 32'h104);
      chk("slli_sel", 32'(out_sel), 32'b010);
      chk("slli_mux3", 32'(out_mux3), 32'd2);
      cyc();
      single(32'h00112423, 32'h108);
      chk("sw_sel", 32'(out_sel), 32'b011);
      chk("sw_mux4", 32'(out_mux4), 32'h008);
      cyc();
      single(32'h123450B7, 32'h10C);
      chk("lui_sel", 32'(out_sel), 32'b100);
      chk("lui_mux5", 32'(out_mux5), 32'h12345);
      cyc();
      single(32'hFE000EE3, 32'h110);
      chk("beq_sel", 32'(out_sel), 32'b110);
      chk("beq_mux7", 32'(out_mux7), 32'hFFE);
      cyc();
      single(32'h0080006F, 32'h114);
      chk("jal_sel", 32'(out_sel), 32'b101);
      chk("jal_mux6", 32'(out_mux6), 32'h00004);
      cyc();
      single(32'h00008067, 32'h118);
      chk("jalr_sel", 32'(out_sel), 32'b001);
      cyc();
      single(32'h0000007F, 32'h11C);
      chk("ill_sel", 32'(out_sel), 32'b111);
      chk("ill_flag", 32'(out_illegal), 32'd1);
      cyc();

      // Backpressure: A, B accepted, C held off until space frees
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00100093; in_pc = 32'h200; cyc();
      in_instr  = 32'h00200113; in_pc = 32'h204; cyc();
      in_instr  = 32'h00300193; in_pc = 32'h208;
      chk("bp_ready_low", 32'(in_ready), 32'd0);
      chk("bp_hold_pc", out_pc, 32'h200);
      cyc();
      chk("bp_hold_pc2", out_pc, 32'h200);
      out_ready = 1'b1;
      cyc();
      chk("bp_b_pc", out_pc, 32'h204);
      cyc();
      in_valid = 1'b0;
      chk("bp_c_pc", out_pc, 32'h208);
      cyc();

      // Streaming at occupancy 1: one per cycle, in_ready stays high
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_instr = rand_instr();
         in_pc    = 32'h300 + 32'(i * 4);
         cyc();
         chk("stream_ready", 32'(in_ready), 32'd1);
         chk("stream_pc", out_pc, 32'h300 + 32'(i * 4));
      end
      in_valid = 1'b0;
      cyc();

      // Flush at occupancy 2 with a concurrent offer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = rand_instr(); in_pc = 32'h400; cyc();
      in_instr  = rand_instr(); in_pc = 32'h404; cyc();
      flush     = 1'b1;
      in_instr  = rand_instr(); in_pc = 32'h408;
      cyc();
      flush     = 1'b0;
      in_valid  = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) cyc();

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_instr  = rand_instr();
         in_pc     = $urandom;
         cyc();
      end
      flush = 1'b0;

      // Asynchronous reset mid-transfer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = rand_instr(); in_pc = 32'h500; cyc();
      in_instr  = rand_instr(); in_pc = 32'h504; cyc();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      reset_outputs_chk("async_rst");
      q.delete();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc();
      single(32'h00500093, 32'h600);
      chk("post_rst_pc", out_pc, 32'h600);
      chk("post_rst_mux2", 32'(out_mux2), 32'h005);
      cyc();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
